// File: rtl/pe_group_ctrl.sv
// Sequencer for one PE group: loads a weight word, streams ifmap rows from BRAM,
// gates the PE pipeline and tags each groupsum with its row/column position.
module pe_group_ctrl #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        layer_in,
    input  logic [CNT_W-1:0]  out_cols,
    input  logic [CNT_W-1:0]  out_rows,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] if_base,
    input  logic [ADDR_W-1:0] if_stride,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              if_rd_en,
    output logic [ADDR_W-1:0] if_addr,
    output logic [3:0]        layer,
    output logic              weight_en,
    output logic              calculate_en,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_col,
    output logic [CNT_W-1:0]  out_row,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int RW = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_FILL, S_CALC, S_DRAIN, S_FIN
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_q, m_q, row_q, col_q;
    logic [3:0]        layer_q;
    logic [ADDR_W-1:0] w_base_q, row_base_q, stride_q, if_addr_q;
    logic [RW-1:0]     rd_left;
    logic [2:0]        vpipe;
    logic              err_q;
    logic [2:0]        fill_f;
    logic              job_ok, accept, row_start, row_last;

    always_comb begin
        case (layer_q)
            4'd1:    fill_f = 3'd5;
            4'd3:    fill_f = 3'd3;
            default: fill_f = 3'd2;
        endcase
    end

    assign job_ok    = ((layer_in == 4'd1) || (layer_in == 4'd3) || (layer_in == 4'd4))
                       && (out_cols != '0) && (out_rows != '0);
    assign accept    = (state == S_IDLE) && start && job_ok;
    assign row_last  = (row_q == m_q - CNT_W'(1));
    assign row_start = (state_nx == S_FILL) && (state != S_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // cnt restarts on every state change; in WLOAD bit 0 separates read and capture cycles
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_WLOAD;
            S_WLOAD: if (cnt == CNT_W'(1)) state_nx = S_FILL;
            S_FILL:  if (cnt == CNT_W'(fill_f)) state_nx = S_CALC;
            S_CALC:  if (cnt == n_q - CNT_W'(1)) state_nx = S_DRAIN;
            S_DRAIN: if (cnt == CNT_W'(2)) state_nx = row_last ? S_FIN : S_FILL;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            n_q        <= '0;
            m_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            layer_q    <= '0;
            w_base_q   <= '0;
            row_base_q <= '0;
            stride_q   <= '0;
            if_addr_q  <= '0;
            rd_left    <= '0;
            vpipe      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !job_ok;
            vpipe <= {vpipe[1:0], state == S_CALC};
            cnt   <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
            if (rd_left != '0) begin
                rd_left   <= rd_left - RW'(1);
                if_addr_q <= if_addr_q + ADDR_W'(1);
            end
            if (vpipe[2]) col_q <= col_q + CNT_W'(1);
            if (accept) begin
                layer_q    <= layer_in;
                n_q        <= out_cols;
                m_q        <= out_rows;
                w_base_q   <= w_base;
                row_base_q <= if_base;
                stride_q   <= if_stride;
                row_q      <= '0;
            end
            // row load overrides the running read/column increments above
            if (row_start) begin
                rd_left <= {1'b0, n_q} + RW'(fill_f) - RW'(1);
                col_q   <= '0;
                if (state == S_DRAIN) begin
                    row_q      <= row_q + CNT_W'(1);
                    row_base_q <= row_base_q + stride_q;
                    if_addr_q  <= row_base_q + stride_q;
                end else begin
                    if_addr_q  <= row_base_q;
                end
            end
        end
    end

    always_comb begin
        w_rd_en      = (state == S_WLOAD) && !cnt[0];
        weight_en    = (state == S_WLOAD) && cnt[0];
        w_addr       = w_rd_en ? w_base_q : '0;
        if_rd_en     = (rd_left != '0);
        if_addr      = if_rd_en ? if_addr_q : '0;
        calculate_en = (state == S_CALC);
        out_valid    = vpipe[2];
        out_col      = col_q;
        out_row      = row_q;
        layer        = layer_q;
        busy         = (state != S_IDLE);
        done         = (state == S_FIN);
        err          = err_q;
    end

endmodule

// File: tb/tb_pe_group_ctrl.sv
// Scoreboard bench for pe_group_ctrl: jobs push timed expected events, a negedge
// monitor pops and compares each event the DUT presents.
module tb_pe_group_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  layer_in;
    logic [7:0]  out_cols, out_rows;
    logic [11:0] w_base, if_base, if_stride;
    logic        w_rd_en, if_rd_en, weight_en, calculate_en, out_valid, busy, done, err;
    logic [11:0] w_addr, if_addr;
    logic [3:0]  layer;
    logic [7:0]  out_col, out_row;

    pe_group_ctrl #(.ADDR_W(12), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_in(layer_in),
        .out_cols(out_cols), .out_rows(out_rows), .w_base(w_base),
        .if_base(if_base), .if_stride(if_stride), .w_rd_en(w_rd_en),
        .w_addr(w_addr), .if_rd_en(if_rd_en), .if_addr(if_addr), .layer(layer),
        .weight_en(weight_en), .calculate_en(calculate_en), .out_valid(out_valid),
        .out_col(out_col), .out_row(out_row), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; int val; } ev_t;
    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cur_layer = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = val;
        sb.push_back(e);
    endtask

    task automatic match(input int kind, input int val, input string nm);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].kind == kind) begin idx = i; break; end
        if (idx < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s unexpected at cycle %0d value 0x%0h", nm, cyc, val);
        end else begin
            chk({nm, "_cycle"}, 64'(cyc), 64'(sb[idx].cyc));
            chk({nm, "_value"}, 64'(val), 64'(sb[idx].val));
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (w_rd_en) begin
                match(0, int'(w_addr), "w_rd");
                chk("layer", 64'(layer), 64'(cur_layer));
            end
            if (weight_en)    match(1, 0, "weight_en");
            if (if_rd_en)     match(2, int'(if_addr), "if_rd");
            if (calculate_en) match(3, 0, "calc_en");
            if (out_valid)    match(4, int'({out_row, out_col}), "out_valid");
            if (done)         match(5, 0, "done");
            if (err)          match(6, 0, "err");
        end
    end

    // expected trace of one job whose w_rd_en falls in cycle t0
    task automatic exp_job(input int t0, input int lay, input int n, input int m,
                           input int wb, input int ib, input int st, output int dcyc);
        int f, c;
        f = (lay == 1) ? 5 : (lay == 3) ? 3 : 2;
        push(0, t0, wb);
        push(1, t0 + 1, 0);
        for (int r = 0; r < m; r++) begin
            c = t0 + 2 + r * (f + n + 4);
            for (int i = 0; i < f + n - 1; i++) push(2, c + i, (ib + r * st + i) & 'hFFF);
            for (int j = 0; j < n; j++) begin
                push(3, c + f + 1 + j, 0);
                push(4, c + f + 4 + j, (r << 8) | j);
            end
        end
        dcyc = t0 + 2 + m * (f + n + 4);
        push(5, dcyc, 0);
    endtask

    task automatic drive(input int lay, input int n, input int m,
                         input int wb, input int ib, input int st);
        layer_in = 4'(lay); out_cols = 8'(n); out_rows = 8'(m);
        w_base = 12'(wb); if_base = 12'(ib); if_stride = 12'(st);
    endtask

    task automatic run_job(input int lay, input int n, input int m,
                           input int wb, input int ib, input int st);
        int t0, d;
        @(negedge clk);
        drive(lay, n, m, wb, ib, st);
        start = 1'b1;
        t0 = cyc + 1;
        cur_layer = lay;
        exp_job(t0, lay, n, m, wb, ib, st, d);
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", 64'(busy), 64'd1);
        while (cyc < d + 1) @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_err(input int lay, input int n, input int m);
        @(negedge clk);
        drive(lay, n, m, 'h70, 'h700, 'h10);
        start = 1'b1;
        push(6, cyc + 1, 0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_err", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("sb_empty_err", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({w_rd_en, if_rd_en, weight_en, calculate_en, out_valid, busy, done, err,
                    layer, w_addr, if_addr, out_col, out_row});
    endfunction

    initial begin
        int t0, t1, d1, d2;
        rst_n = 1'b0; start = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("reset_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(1, 4, 1, 'h10, 'h100, 'h0);
        run_job(4, 3, 2, 'h20, 'h100, 'h20);
        run_job(3, 1, 1, 'h30, 'h200, 'h10);
        run_job(3, 1, 1, 'h40, 'hFFE, 'h0);
        run_err(2, 4, 1);
        run_err(1, 0, 1);
        run_err(3, 2, 0);

        // reset in the middle of CALC, then a fresh job
        @(negedge clk);
        drive(3, 4, 1, 'h60, 'h400, 'h0);
        start = 1'b1;
        t0 = cyc + 1;
        cur_layer = 3;
        exp_job(t0, 3, 4, 1, 'h60, 'h400, 'h0, d1);
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 7) @(negedge clk);
        chk("calc_before_reset", 64'(calculate_en), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_job(3, 2, 1, 'h61, 'h410, 'h0);

        // start held high: one job per IDLE entry, none taken in the done cycle
        @(negedge clk);
        drive(4, 1, 1, 'h50, 'h300, 'h0);
        start = 1'b1;
        t0 = cyc + 1;
        cur_layer = 4;
        exp_job(t0, 4, 1, 1, 'h50, 'h300, 'h0, d1);
        t1 = d1 + 2;
        exp_job(t1, 4, 1, 1, 'h50, 'h300, 'h0, d2);
        while (cyc < t1) @(negedge clk);
        start = 1'b0;
        while (cyc < d2 + 1) @(negedge clk);
        chk("busy_held", 64'(busy), 64'd0);
        chk("sb_empty_held", 64'(sb.size()), 64'd0);

        run_job(4, 255, 1, 'h80, 'h800, 'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
